// File: rtl/alu_pipe_if.sv
// alu_pipe_if: valid/ready bundle between the operand source, alu_pipe and writeback.
//   Request side : in_valid, in_ready, in_a, in_b, carry_in, use_flag_carry, select, mode
//   Result side  : out_valid, out_ready, alu_out, carry_out, overflow, zero, negative, compare
//   master modport = producer of operations and consumer of results; slave = the ALU.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             carry_in;
    logic             use_flag_carry;
    logic [3:0]       select;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             compare;

    modport master (
        output in_valid, in_a, in_b, carry_in, use_flag_carry, select, mode, out_ready,
        input  in_ready, out_valid, alu_out, carry_out, overflow, zero, negative, compare
    );

    modport slave (
        input  in_valid, in_a, in_b, carry_in, use_flag_carry, select, mode, out_ready,
        output in_ready, out_valid, alu_out, carry_out, overflow, zero, negative, compare
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result and flags (arith, logic, shift, multiply).
//   clk    : clock
//   rst    : synchronous active-high reset (aborts an in-flight multiply)
//   io_bus : alu_pipe_if.slave, request and result valid/ready channels
// Build option ALU_MUL_EN: when defined, mode 11 is a WIDTH-cycle shift-add multiplier;
// when undefined, mode 11 completes in one cycle with a zero result.
module alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  io_bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

    state_e r_state, w_state_d;

    logic [WIDTH-1:0] r_alu_out;
    logic             r_carry, r_ovf, r_zero, r_neg, r_cmp, r_flag_c;

    logic [WIDTH-1:0] w_a, w_b;
    logic [3:0]       w_sel;
    logic             w_c, w_accept, w_is_mul;

    assign w_a   = io_bus.in_a;
    assign w_b   = io_bus.in_b;
    assign w_sel = io_bus.select;
    assign w_c   = io_bus.use_flag_carry ? r_flag_c : io_bus.carry_in;

    assign io_bus.in_ready  = !rst && ((r_state == StIdle) ||
                                      (r_state == StHold && io_bus.out_ready));
    assign w_accept         = io_bus.in_valid && io_bus.in_ready;
    assign io_bus.out_valid = (r_state == StHold);
    assign io_bus.alu_out   = r_alu_out;
    assign io_bus.carry_out = r_carry;
    assign io_bus.overflow  = r_ovf;
    assign io_bus.zero      = r_zero;
    assign io_bus.negative  = r_neg;
    assign io_bus.compare   = r_cmp;

    // Arithmetic: every op is x + y + cin. Reserved selects fall through to A + 0 + 0,
    // which yields A with no carry and no overflow.
    logic [WIDTH-1:0] w_ax, w_ay;
    logic             w_acin, w_aovf;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_ax   = w_a;
        w_ay   = '0;
        w_acin = 1'b0;
        case (w_sel)
            4'd0: begin w_ay = w_b;  w_acin = w_c;  end
            4'd1: begin w_ay = ~w_b; w_acin = 1'b1; end
            4'd2: begin w_ay = ~w_b; w_acin = w_c;  end
            4'd3: w_acin = 1'b1;
            4'd4: w_ay = '1;
            4'd5: begin w_ay = w_a;  w_acin = w_c;  end
            4'd6: begin w_ax = ~w_a; w_acin = 1'b1; end
            default: ;
        endcase
    end

    assign w_sum  = {1'b0, w_ax} + {1'b0, w_ay} + {{WIDTH{1'b0}}, w_acin};
    assign w_aovf = (w_ax[WIDTH-1] == w_ay[WIDTH-1]) && (w_sum[WIDTH-1] != w_ax[WIDTH-1]);

    // Shifts carry one guard bit so the last bit shifted out lands in a fixed position;
    // n == 0 leaves the guard bit at 0.
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH:0]     w_sll, w_srl, w_sra;
    logic [2*WIDTH-1:0] w_rol;

    assign w_shamt = w_b[SHAMT_W-1:0];
    assign w_sll   = {1'b0, w_a} << w_shamt;
    assign w_srl   = {w_a, 1'b0} >> w_shamt;
    assign w_sra   = $signed({w_a, 1'b0}) >>> w_shamt;
    assign w_rol   = {w_a, w_a} << w_shamt;

    logic [WIDTH-1:0] w_res;
    logic             w_carry, w_ovf;

    always_comb begin
        w_res   = w_a;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        unique case (io_bus.mode)
            2'b00: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = w_aovf;
            end
            2'b01: begin
                case (w_sel)
                    4'h0: w_res = ~w_a;
                    4'h1: w_res = ~(w_a | w_b);
                    4'h2: w_res = ~w_a & w_b;
                    4'h3: w_res = '0;
                    4'h4: w_res = ~(w_a & w_b);
                    4'h5: w_res = ~w_b;
                    4'h6: w_res = w_a ^ w_b;
                    4'h7: w_res = w_a & ~w_b;
                    4'h8: w_res = ~w_a | w_b;
                    4'h9: w_res = ~(w_a ^ w_b);
                    4'hA: w_res = w_b;
                    4'hB: w_res = w_a & w_b;
                    4'hC: w_res = '1;
                    4'hD: w_res = w_a | ~w_b;
                    4'hE: w_res = w_a | w_b;
                    4'hF: w_res = w_a;
                endcase
            end
            2'b10: begin
                case (w_sel[1:0])
                    2'b00: begin w_res = w_sll[WIDTH-1:0]; w_carry = w_sll[WIDTH]; end
                    2'b01: begin w_res = w_srl[WIDTH:1];   w_carry = w_srl[0];     end
                    2'b10: begin w_res = w_sra[WIDTH:1];   w_carry = w_sra[0];     end
                    2'b11: begin
                        w_res   = w_rol[2*WIDTH-1:WIDTH];
                        w_carry = (w_shamt != '0) && w_rol[WIDTH];
                    end
                endcase
            end
            2'b11: w_res = '0;
        endcase
    end

    // Output register load sources: single-cycle result on accept, or multiplier finish.
    logic             w_ld;
    logic [WIDTH-1:0] w_ld_res;
    logic             w_ld_carry, w_ld_ovf, w_ld_cmp;

`ifdef ALU_MUL_EN
    localparam logic [SHAMT_W-1:0] CntLast = SHAMT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;     // {partial high, remaining multiplier bits}
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_mcmp;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mdone;

    assign w_is_mul   = (io_bus.mode == 2'b11);
    assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {w_madd, r_acc[WIDTH-1:1]};
    assign w_mdone    = (r_state == StMul) && (r_cnt == CntLast);

    always_comb begin
        w_ld       = (w_accept && !w_is_mul) || w_mdone;
        w_ld_res   = w_res;
        w_ld_carry = w_carry;
        w_ld_ovf   = w_ovf;
        w_ld_cmp   = (w_a == w_b);
        if (w_mdone) begin
            w_ld_res   = w_acc_next[WIDTH-1:0];
            w_ld_carry = |w_acc_next[2*WIDTH-1:WIDTH];
            w_ld_ovf   = 1'b0;
            w_ld_cmp   = r_mcmp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_mcmp  <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            r_mcand <= w_a;
            r_acc   <= {{WIDTH{1'b0}}, w_b};
            r_cnt   <= '0;
            r_mcmp  <= (w_a == w_b);
        end else if (r_state == StMul) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_is_mul = 1'b0;

    always_comb begin
        w_ld       = w_accept;
        w_ld_res   = w_res;
        w_ld_carry = w_carry;
        w_ld_ovf   = w_ovf;
        w_ld_cmp   = (w_a == w_b);
    end
`endif

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: if (w_accept) w_state_d = w_is_mul ? StMul : StHold;
`ifdef ALU_MUL_EN
            StMul:  if (w_mdone) w_state_d = StHold;
`endif
            StHold: begin
                if (io_bus.out_ready) begin
                    if (w_accept) w_state_d = w_is_mul ? StMul : StHold;
                    else          w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_alu_out <= '0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_cmp     <= 1'b0;
            r_flag_c  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_ld) begin
                r_alu_out <= w_ld_res;
                r_carry   <= w_ld_carry;
                r_ovf     <= w_ld_ovf;
                r_zero    <= (w_ld_res == '0);
                r_neg     <= w_ld_res[WIDTH-1];
                r_cmp     <= w_ld_cmp;
                r_flag_c  <= w_ld_carry;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    alu_pipe_if #(.WIDTH(16)) bus ();

    alu_pipe #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {carry_out, overflow, zero, negative, compare}
    function automatic logic [4:0] flags();
        return {bus.carry_out, bus.overflow, bus.zero, bus.negative, bus.compare};
    endfunction

    task automatic op(input logic [1:0] m, input logic [3:0] s, input logic [15:0] a,
                      input logic [15:0] b, input logic ci, input logic ufc);
        bus.in_valid       = 1'b1;
        bus.mode           = m;
        bus.select         = s;
        bus.in_a           = a;
        bus.in_b           = b;
        bus.carry_in       = ci;
        bus.use_flag_carry = ufc;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef ALU_MUL_EN
    // Counts edges from the accepting edge until out_valid rises; 0 on timeout.
    task automatic wait_result(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                n = i;
                break;
            end
        end
    endtask
`endif

    initial begin
        int lat;
        bit stray;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        op(2'b00, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        step();
        step();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_alu_out", bus.alu_out, 0);
        chk("rst_flags", flags(), 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", bus.in_ready, 1);

        // A+B+c wraps to zero with carry
        op(2'b00, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step();
        chk("add_valid", bus.out_valid, 1);
        chk("add_out", bus.alu_out, 16'h0000);
        chk("add_flags", flags(), 5'b10100);

        // back-to-back using the stored carry
        op(2'b00, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        #1;
        chk("b2b_in_ready", bus.in_ready, 1);
        step();
        chk("flagc_out", bus.alu_out, 16'h0001);
        chk("flagc_flags", flags(), 5'b00001);

        op(2'b00, 4'd1, 16'h8000, 16'h0001, 1'b0, 1'b0);
        step();
        chk("sub_out", bus.alu_out, 16'h7FFF);
        chk("sub_flags", flags(), 5'b11000);

        // backpressure: result held, no accept
        bus.out_ready = 1'b0;
        op(2'b00, 4'd3, 16'h0005, 16'h0000, 1'b0, 1'b0);
        #1;
        chk("bp_in_ready0", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_stable", bus.alu_out, 16'h7FFF);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.in_ready, 1);
        step();
        chk("inc_out", bus.alu_out, 16'h0006);
        chk("inc_flags", flags(), 5'b00000);

        op(2'b10, 4'd2, 16'h8001, 16'h0004, 1'b0, 1'b0);
        step();
        chk("sra_out", bus.alu_out, 16'hF800);
        chk("sra_flags", flags(), 5'b00010);

        op(2'b10, 4'd3, 16'h8000, 16'h0001, 1'b0, 1'b0);
        step();
        chk("rol_out", bus.alu_out, 16'h0001);
        chk("rol_flags", flags(), 5'b10000);

        op(2'b01, 4'd6, 16'hF0F0, 16'hFF00, 1'b0, 1'b0);
        step();
        chk("xor_out", bus.alu_out, 16'h0FF0);
        chk("xor_flags", flags(), 5'b00000);

        // SLL by 15: last bit out is A[1]; select[3:2] ignored
        op(2'b10, 4'b1100, 16'h0003, 16'h000F, 1'b0, 1'b0);
        step();
        chk("sll_out", bus.alu_out, 16'h8000);
        chk("sll_flags", flags(), 5'b10010);

        // A+A+flag_c with signed overflow
        op(2'b00, 4'd5, 16'h4000, 16'h0000, 1'b0, 1'b1);
        step();
        chk("dbl_out", bus.alu_out, 16'h8001);
        chk("dbl_flags", flags(), 5'b01010);

        op(2'b00, 4'd9, 16'h1234, 16'h0000, 1'b1, 1'b0);
        step();
        chk("rsvd_out", bus.alu_out, 16'h1234);
        chk("rsvd_flags", flags(), 5'b00000);

        // shift by zero
        op(2'b10, 4'd1, 16'h8000, 16'h0010, 1'b0, 1'b0);
        step();
        chk("srl0_out", bus.alu_out, 16'h8000);
        chk("srl0_flags", flags(), 5'b00010);

        op(2'b01, 4'hD, 16'h00F0, 16'h0F0F, 1'b0, 1'b0);
        step();
        chk("orn_out", bus.alu_out, 16'hF0F0);

        // drain: outputs hold while invalid
        bus.in_valid = 1'b0;
        step();
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_hold", bus.alu_out, 16'hF0F0);
        chk("drain_in_ready", bus.in_ready, 1);

`ifdef ALU_MUL_EN
        op(2'b11, 4'd0, 16'h00FF, 16'h0003, 1'b0, 1'b0);
        wait_result(lat);
        chk("mul1_latency", lat, 17);
        chk("mul1_out", bus.alu_out, 16'h02FD);
        chk("mul1_flags", flags(), 5'b00000);

        op(2'b11, 4'd7, 16'h0100, 16'h0100, 1'b0, 1'b0);
        wait_result(lat);
        chk("mul2_latency", lat, 17);
        chk("mul2_out", bus.alu_out, 16'h0000);
        chk("mul2_flags", flags(), 5'b10101);

        // reset in the 5th multiply cycle
        op(2'b11, 4'd0, 16'h0003, 16'h0005, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("mul3_busy", bus.in_ready, 0);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
`else
        op(2'b11, 4'd0, 16'h1234, 16'h1234, 1'b0, 1'b0);
        step();
        chk("mul_off_valid", bus.out_valid, 1);
        chk("mul_off_out", bus.alu_out, 16'h0000);
        chk("mul_off_flags", flags(), 5'b00101);

        // reset while a result is held
        op(2'b00, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("pre_rst_carry", bus.carry_out, 1);
        rst = 1'b1;
        step();
        bus.out_ready = 1'b1;
`endif
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_out", bus.alu_out, 0);
        chk("mrst_flags", flags(), 0);
        chk("mrst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("mrst_ready_after", bus.in_ready, 1);
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.out_valid) stray = 1'b1;
        end
        chk("mrst_no_result", stray, 0);

        // flag_c was cleared by reset
        op(2'b00, 4'd0, 16'h0000, 16'h0001, 1'b0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("flagc_rst_out", bus.alu_out, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
